// File: rtl/dpram_port_master.sv
// Request-to-RAM port master: 1-cycle reads/writes with a 2-edge read response.
// Define DPRAM_PORT_MASTER_RMW_EN to turn partial-byte writes into read-modify-write.
module dpram_port_master #(
  parameter int addr_width = 8,
  parameter int data_width = 16
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [addr_width-1:0]   req_addr,
  input  logic [data_width-1:0]   req_wdata,
  input  logic [data_width/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [data_width-1:0]   rsp_rdata,
  output logic [addr_width-1:0]   ram_address,
  output logic [data_width-1:0]   ram_data,
  output logic                    ram_wren,
  output logic                    ram_cs,
  input  logic [data_width-1:0]   ram_q
);

  localparam int NB = data_width / 8;

  logic be_none;
  logic be_full;
  logic acc;
  logic in_idle;
  logic issue_cs;
  logic issue_wren;
  logic rd_pend;

  assign be_none = (req_be == '0);
  assign be_full = &req_be;
  assign acc     = req_valid && req_ready;

`ifdef DPRAM_PORT_MASTER_RMW_EN
  typedef enum logic {IDLE, RMW} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [addr_width-1:0]   lat_addr;
  logic [data_width-1:0]   lat_wdata;
  logic [NB-1:0]           lat_be;
  logic [data_width-1:0]   merged;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (acc && req_we && !be_none && !be_full)
              state_nxt = RMW;
      RMW:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (acc) begin
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // ram_q holds the old word read on the accepting edge
  always_comb begin
    merged = ram_q;
    for (int i = 0; i < NB; i++)
      if (lat_be[i]) merged[8*i +: 8] = lat_wdata[8*i +: 8];
  end

  always_comb begin
    in_idle     = 1'b0;
    ram_address = req_addr;
    ram_data    = req_wdata;
    issue_cs    = 1'b0;
    issue_wren  = 1'b0;
    unique case (state)
      IDLE: begin
        in_idle    = 1'b1;
        issue_cs   = req_valid && (!req_we || !be_none);
        issue_wren = req_valid && req_we && be_full;
      end
      RMW: begin
        ram_address = lat_addr;
        ram_data    = merged;
        issue_cs    = 1'b1;
        issue_wren  = 1'b1;
      end
      default: ;
    endcase
  end
`else
  assign in_idle     = 1'b1;
  assign ram_address = req_addr;
  assign ram_data    = req_wdata;
  assign issue_cs    = req_valid && (!req_we || !be_none);
  assign issue_wren  = req_valid && req_we && !be_none;
`endif

  assign req_ready = reset_n && in_idle;
  assign ram_cs    = reset_n && issue_cs;
  assign ram_wren  = reset_n && issue_wren;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rd_pend   <= acc && !req_we;
      rsp_valid <= rd_pend;
      if (rd_pend) rsp_rdata <= ram_q;
    end
  end

endmodule

// File: tb/tb_dpram_port_master.sv
// Bench for dpram_port_master: vector table, directed corner cases,
// and random traffic against a word-array reference model.
module tb_dpram_port_master;

`ifdef DPRAM_PORT_MASTER_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [7:0]  ram_address;
  logic [15:0] ram_data;
  logic        ram_wren;
  logic        ram_cs;
  logic [15:0] ram_q;

  int nchk = 0;
  int nerr = 0;

  logic [15:0] mem [256];
  logic [15:0] ref_mem [256];

  typedef struct {
    logic        v;
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;
    logic [1:0]  be;
    logic        e_cs;
    logic        e_wren;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] d;
  } rsp_t;

  vec_t tbl [7];
  rsp_t exp_q [$];

  always #5 clock = ~clock;

  dpram_port_master #(.addr_width(8), .data_width(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .ram_address(ram_address), .ram_data(ram_data),
    .ram_wren(ram_wren), .ram_cs(ram_cs), .ram_q(ram_q)
  );

  // synchronous RAM, read-first, registered output
  always @(posedge clock) begin
    if (ram_cs) begin
      ram_q <= mem[ram_address];
      if (ram_wren) mem[ram_address] <= ram_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [7:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    @(negedge clock);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00);
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old,
                                        input logic [15:0] d,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    for (int l = 0; l < 2; l++)
      if (be[l]) r[8*l +: 8] = d[8*l +: 8];
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    ram_q = '0;

    // reset state, with a request already pending
    drive(1'b1, 1'b0, 8'h10, 16'h0000, 2'b11);
    chk("rst_ready", req_ready, 0);
    chk("rst_cs", ram_cs, 0);
    chk("rst_wren", ram_wren, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge clock);
    reset_n = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1);

    // vector table: single-cycle combinational behaviour in IDLE
    tbl[0] = '{1'b1, 1'b0, 8'h05, 16'h0000, 2'b11, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 8'h06, 16'h1357, 2'b11, 1'b1, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 8'h07, 16'h2468, 2'b00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 8'h08, 16'hA5A5, 2'b01, 1'b1, !RMW};
    tbl[4] = '{1'b1, 1'b1, 8'h09, 16'h5A5A, 2'b10, 1'b1, !RMW};
    tbl[5] = '{1'b0, 1'b1, 8'h0A, 16'hFFFF, 2'b11, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 8'h0B, 16'h0001, 2'b11, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].v, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].be);
      chk($sformatf("tbl%0d_ready", i), req_ready, 1);
      chk($sformatf("tbl%0d_cs", i), ram_cs, tbl[i].e_cs);
      chk($sformatf("tbl%0d_wren", i), ram_wren, tbl[i].e_wren);
      chk($sformatf("tbl%0d_addr", i), ram_address, tbl[i].a);
      chk($sformatf("tbl%0d_data", i), ram_data, tbl[i].d);
      idle();
      idle();
    end

    // single read, 2-edge latency
    mem[8'h10] = 16'hBEEF;
    drive(1'b1, 1'b0, 8'h10, 16'h0000, 2'b11);
    chk("rd_cs", ram_cs, 1);
    chk("rd_wren", ram_wren, 0);
    idle();
    chk("rd_early", rsp_valid, 0);
    idle();
    chk("rd_valid", rsp_valid, 1);
    chk("rd_data", rsp_rdata, 16'hBEEF);
    idle();
    chk("rd_pulse", rsp_valid, 0);

    // back-to-back reads
    mem[8'h01] = 16'h1111;
    mem[8'h02] = 16'h2222;
    mem[8'h03] = 16'h3333;
    for (int s = 0; s < 6; s++) begin
      logic [15:0] ed;
      ed = (s == 2) ? 16'h1111 : (s == 3) ? 16'h2222 : 16'h3333;
      if (s < 3) drive(1'b1, 1'b0, 8'(s + 1), 16'h0000, 2'b11);
      else       idle();
      chk($sformatf("b2b%0d_ready", s), req_ready, 1);
      chk($sformatf("b2b%0d_valid", s), rsp_valid, (s >= 2 && s <= 4));
      if (s >= 2 && s <= 4)
        chk($sformatf("b2b%0d_data", s), rsp_rdata, ed);
    end

    // partial write
    mem[8'h20] = 16'h1234;
    drive(1'b1, 1'b1, 8'h20, 16'hAB00, 2'b10);
    chk("pw_cs", ram_cs, 1);
    chk("pw_wren", ram_wren, !RMW);
    idle();
    chk("pw_ready2", req_ready, !RMW);
    chk("pw_wren2", ram_wren, RMW);
    if (!req_ready) idle();
    drive(1'b1, 1'b0, 8'h20, 16'h0000, 2'b11);
    idle();
    idle();
    chk("pw_rd_valid", rsp_valid, 1);
    chk("pw_rd_data", rsp_rdata, RMW ? 16'hAB34 : 16'hAB00);

    // zero byte-enable write
    mem[8'h30] = 16'h5555;
    drive(1'b1, 1'b1, 8'h30, 16'hFFFF, 2'b00);
    chk("zw_wren", ram_wren, 0);
    chk("zw_cs", ram_cs, 0);
    idle();
    chk("zw_wren2", ram_wren, 0);
    drive(1'b1, 1'b0, 8'h30, 16'h0000, 2'b11);
    idle();
    idle();
    chk("zw_rd_data", rsp_rdata, 16'h5555);

    // reset during the cycle after a partial write, with a read in flight
    mem[8'h40] = 16'h1234;
    drive(1'b1, 1'b0, 8'h41, 16'h0000, 2'b11);
    drive(1'b1, 1'b1, 8'h40, 16'hAB00, 2'b10);
    @(negedge clock);
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("ra_wren", ram_wren, 0);
    chk("ra_cs", ram_cs, 0);
    chk("ra_ready", req_ready, 0);
    chk("ra_rsp", rsp_valid, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("ra_ready_rel", req_ready, 1);
    chk("ra_rsp_rel", rsp_valid, 0);
    chk("ra_mem", mem[8'h40], RMW ? 16'h1234 : 16'hAB00);
    idle();
    chk("ra_rsp_rel2", rsp_valid, 0);

    // random traffic against the reference model
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    begin
      bit busy;
      busy = 1'b0;
      for (int cyc = 0; cyc < 420; cyc++) begin
        logic        v;
        logic        we;
        logic [7:0]  a;
        logic [15:0] d;
        logic [1:0]  be;
        logic        ev;
        v  = (cyc < 400) && ($urandom_range(0, 3) != 0);
        we = 1'($urandom_range(0, 1));
        a  = 8'($urandom_range(0, 15));
        d  = 16'($urandom);
        be = 2'($urandom_range(0, 3));
        drive(v, we, a, d, be);
        chk("rnd_ready", req_ready, !busy);
        ev = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        chk("rnd_valid", rsp_valid, ev);
        if (ev) begin
          chk("rnd_data", rsp_rdata, exp_q[0].d);
          void'(exp_q.pop_front());
        end
        if (v && !busy) begin
          if (!we) begin
            exp_q.push_back('{cyc + 2, ref_mem[a]});
            busy = 1'b0;
          end else begin
            if (be != 2'b00)
              ref_mem[a] = RMW ? merge(ref_mem[a], d, be) : d;
            busy = RMW && (be == 2'b01 || be == 2'b10);
          end
        end else begin
          busy = 1'b0;
        end
      end
    end
    chk("rnd_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
